// File: rtl/rsa_avmm_wrapper.sv
// rsa_avmm_wrapper: bridges a UART (Avalon-MM slave) to a 256-bit RSA modexp core.
// Receives modulus, exponent and ciphertext as 96 MSB-first bytes, starts the core,
// then transmits the low 31 bytes of the result. Later messages reuse n and e and
// receive only a new 32-byte ciphertext.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   avm_address/read/write       Avalon-MM master request (registered)
//   avm_writedata/readdata       Avalon-MM data
//   avm_waitrequest              slave stall
//   core_src_val/rdy             operand handshake to the core
//   core_a/e/n                   ciphertext, exponent, modulus (registered)
//   core_result_val/rdy          result handshake from the core
//   core_result                  a^e mod n
module rsa_avmm_wrapper #(
    parameter int unsigned RX_BASE     = 0,
    parameter int unsigned TX_BASE     = 4,
    parameter int unsigned STATUS_BASE = 8,
    parameter int unsigned RX_OK_BIT   = 7,
    parameter int unsigned TX_OK_BIT   = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    output logic         avm_write,
    input  logic [31:0]  avm_readdata,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         core_src_val,
    input  logic         core_src_rdy,
    output logic [255:0] core_a,
    output logic [255:0] core_e,
    output logic [255:0] core_n,
    input  logic         core_result_val,
    output logic         core_result_rdy,
    input  logic [255:0] core_result
);

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned RX_CNT_W = 7;
    localparam int unsigned TX_CNT_W = 5;
    localparam int unsigned RES_W    = 248;

    localparam logic [ADDR_W-1:0]   RX_ADDR      = ADDR_W'(RX_BASE);
    localparam logic [ADDR_W-1:0]   TX_ADDR      = ADDR_W'(TX_BASE);
    localparam logic [ADDR_W-1:0]   STATUS_ADDR  = ADDR_W'(STATUS_BASE);
    localparam logic [RX_CNT_W-1:0] E_FIRST      = RX_CNT_W'(32);
    localparam logic [RX_CNT_W-1:0] A_FIRST      = RX_CNT_W'(64);
    localparam logic [RX_CNT_W-1:0] RX_LAST      = RX_CNT_W'(95);
    localparam logic [TX_CNT_W-1:0] TX_LAST      = TX_CNT_W'(30);

    typedef enum logic [2:0] {
        QUERY_RX,
        READ_RX,
        START_CORE,
        WAIT_CORE,
        QUERY_TX,
        WRITE_TX
    } state_t;

    state_t                state;
    logic [RX_CNT_W-1:0]   rx_cnt;
    logic [TX_CNT_W-1:0]   tx_cnt;
    // Only result bits 247:0 are ever transmitted, so the top byte is not stored.
    logic [RES_W-1:0]      result;
    logic [7:0]            rx_byte;
    logic                  xfer_done;

    // Upper status/data bits and the untransmitted result byte carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{avm_readdata[31:8], core_result[255:248]};

    assign rx_byte   = avm_readdata[7:0];
    // A transfer completes in a cycle where a request is up and the slave does not stall.
    assign xfer_done = (avm_read || avm_write) && !avm_waitrequest;

    // Control FSM; every output is a register updated only on transfer completion,
    // so address/data/strobes are held while the slave stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= QUERY_RX;
            rx_cnt          <= '0;
            tx_cnt          <= '0;
            result          <= '0;
            avm_address     <= '0;
            avm_read        <= 1'b0;
            avm_write       <= 1'b0;
            avm_writedata   <= '0;
            core_src_val    <= 1'b0;
            core_result_rdy <= 1'b0;
            core_a          <= '0;
            core_e          <= '0;
            core_n          <= '0;
        end else begin
            case (state)
                QUERY_RX: begin
                    if (!avm_read) begin
                        // First poll after reset
                        avm_read    <= 1'b1;
                        avm_address <= STATUS_ADDR;
                    end else if (xfer_done && avm_readdata[RX_OK_BIT]) begin
                        avm_address <= RX_ADDR;
                        state       <= READ_RX;
                    end
                    // OK bit clear: read stays up, issuing the next poll
                end

                READ_RX: begin
                    if (xfer_done) begin
                        if (rx_cnt < E_FIRST) begin
                            core_n <= {core_n[247:0], rx_byte};
                        end else if (rx_cnt < A_FIRST) begin
                            core_e <= {core_e[247:0], rx_byte};
                        end else begin
                            core_a <= {core_a[247:0], rx_byte};
                        end
                        rx_cnt <= rx_cnt + RX_CNT_W'(1);
                        if (rx_cnt == RX_LAST) begin
                            avm_read     <= 1'b0;
                            core_src_val <= 1'b1;
                            state        <= START_CORE;
                        end else begin
                            avm_address <= STATUS_ADDR;
                            state       <= QUERY_RX;
                        end
                    end
                end

                START_CORE: begin
                    if (core_src_val && core_src_rdy) begin
                        core_src_val    <= 1'b0;
                        core_result_rdy <= 1'b1;
                        state           <= WAIT_CORE;
                    end
                end

                WAIT_CORE: begin
                    if (core_result_rdy && core_result_val) begin
                        result          <= core_result[RES_W-1:0];
                        core_result_rdy <= 1'b0;
                        avm_read        <= 1'b1;
                        avm_address     <= STATUS_ADDR;
                        state           <= QUERY_TX;
                    end
                end

                QUERY_TX: begin
                    if (xfer_done && avm_readdata[TX_OK_BIT]) begin
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b1;
                        avm_address   <= TX_ADDR;
                        avm_writedata <= {24'b0, result[RES_W-1 -: 8]};
                        state         <= WRITE_TX;
                    end
                end

                WRITE_TX: begin
                    if (xfer_done) begin
                        result      <= {result[RES_W-9:0], 8'h00};
                        avm_write   <= 1'b0;
                        avm_read    <= 1'b1;
                        avm_address <= STATUS_ADDR;
                        if (tx_cnt == TX_LAST) begin
                            // Keep n and e; only a new ciphertext is received next
                            tx_cnt <= '0;
                            rx_cnt <= A_FIRST;
                            state  <= QUERY_RX;
                        end else begin
                            tx_cnt <= tx_cnt + TX_CNT_W'(1);
                            state  <= QUERY_TX;
                        end
                    end
                end

                default: begin
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                    state     <= QUERY_RX;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_avmm_wrapper.sv
// Directed bench for rsa_avmm_wrapper: UART slave model with stall/status control,
// a simple modexp core responder, and per-scenario checking tasks.
module tb_rsa_avmm_wrapper;

    localparam logic [255:0] EXP_N   = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
    localparam logic [255:0] EXP_E   = 256'h2122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f40;
    localparam logic [255:0] EXP_A   = 256'h4142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f60;
    localparam logic [255:0] EXP_A2  = 256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
    localparam logic [255:0] EXP_C0  = 256'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecfd0d1d2d3d4d5d6d7d8d9dadbdcdddedf;
    localparam logic [255:0] RES1    = 256'hff1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [255:0] RES2    = 256'haa808182838485868788898a8b8c8d8e8f909192939495969798999a9b9c9d9e;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic         avm_write;
    logic [31:0]  avm_readdata = '0;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest = 1'b0;
    logic         core_src_val;
    logic         core_src_rdy = 1'b0;
    logic [255:0] core_a;
    logic [255:0] core_e;
    logic [255:0] core_n;
    logic         core_result_val = 1'b0;
    logic         core_result_rdy;
    logic [255:0] core_result = '0;

    int checks = 0;
    int errors = 0;

    // Slave model state
    logic [7:0]  rx_q[$];
    logic [31:0] tx_q[$];
    int          stall_cycles = 0;
    int          rx_ok_hold   = 0;
    int          tx_ok_hold   = 0;
    int          proto_err    = 0;
    int          stab_err     = 0;
    bit          tx_ok_seen   = 0;
    logic [255:0] res_word    = '0;

    rsa_avmm_wrapper dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_readdata    (avm_readdata),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .core_src_val    (core_src_val),
        .core_src_rdy    (core_src_rdy),
        .core_a          (core_a),
        .core_e          (core_e),
        .core_n          (core_n),
        .core_result_val (core_result_val),
        .core_result_rdy (core_result_rdy),
        .core_result     (core_result)
    );

    initial forever #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // UART Avalon slave: stalls each transfer, serves status/RX bytes, records TX writes
    initial begin : uart_slave
        bit          in_xfer;
        int          stall_left;
        logic [4:0]  l_addr;
        logic        l_rd;
        logic        l_wr;
        logic [31:0] l_wd;
        bit          rx_ok;
        bit          tx_ok;
        logic [31:0] rd;
        in_xfer = 0;
        stall_left = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                avm_waitrequest = 1'b0;
                in_xfer = 0;
            end else if (!avm_read && !avm_write) begin
                avm_waitrequest = 1'b0;
                in_xfer = 0;
            end else begin
                if (avm_read && avm_write) proto_err++;
                if (!in_xfer) begin
                    in_xfer    = 1;
                    stall_left = stall_cycles;
                    l_addr = avm_address; l_rd = avm_read; l_wr = avm_write; l_wd = avm_writedata;
                end else if (avm_address !== l_addr || avm_read !== l_rd ||
                             avm_write !== l_wr || avm_writedata !== l_wd) begin
                    stab_err++;
                end
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    in_xfer = 0;
                    if (avm_read && avm_address == 5'd8) begin
                        rx_ok = (rx_q.size() > 0) && (rx_ok_hold == 0);
                        tx_ok = (tx_ok_hold == 0);
                        if (rx_ok_hold > 0) rx_ok_hold--;
                        if (tx_ok_hold > 0) tx_ok_hold--;
                        if (tx_ok) tx_ok_seen = 1;
                        rd = $urandom;
                        rd[7] = rx_ok;
                        rd[6] = tx_ok;
                        avm_readdata = rd;
                    end else if (avm_read && avm_address == 5'd0) begin
                        if (rx_q.size() == 0) begin
                            proto_err++;
                            avm_readdata = '0;
                        end else begin
                            avm_readdata = {24'hABCDEF, rx_q.pop_front()};
                        end
                    end else if (avm_write && avm_address == 5'd4) begin
                        if (!tx_ok_seen) proto_err++;
                        tx_ok_seen = 0;
                        tx_q.push_back(avm_writedata);
                    end else begin
                        proto_err++;
                    end
                end
            end
        end
    end

    // Core model: accepts operands 3 cycles after valid, then offers res_word until taken
    initial begin : core_model
        int src_cnt;
        bit prev_rrdy;
        src_cnt = 0;
        prev_rrdy = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                core_src_rdy    = 1'b0;
                core_result_val = 1'b0;
                src_cnt         = 0;
                prev_rrdy       = 0;
            end else begin
                if (core_src_val && rx_q.size() != 0) proto_err++;
                if (core_src_rdy) begin
                    core_src_rdy    = 1'b0;
                    src_cnt         = 0;
                    core_result_val = 1'b1;
                    core_result     = res_word;
                end else if (core_src_val) begin
                    src_cnt++;
                    if (src_cnt >= 3) core_src_rdy = 1'b1;
                end else if (core_result_val && prev_rrdy && !core_result_rdy) begin
                    core_result_val = 1'b0;
                end
                prev_rrdy = core_result_rdy;
            end
        end
    end

    task automatic push_bytes(input logic [7:0] first, input int n);
        logic [7:0] b;
        b = first;
        repeat (n) begin
            rx_q.push_back(b);
            b = b + 8'd1;
        end
    endtask

    task automatic wait_src_val(input int limit, output bit ok);
        ok = 0;
        for (int k = 0; k < limit; k++) begin
            @(posedge i_clk); #1;
            if (core_src_val === 1'b1) begin ok = 1; break; end
        end
    endtask

    task automatic wait_txq(input int n, input int limit, output bit ok);
        ok = 0;
        for (int k = 0; k < limit; k++) begin
            @(posedge i_clk); #1;
            if (tx_q.size() >= n) begin ok = 1; break; end
        end
    endtask

    task automatic wait_rxq(input int n, input int limit, output bit ok);
        ok = 0;
        for (int k = 0; k < limit; k++) begin
            @(posedge i_clk); #1;
            if (rx_q.size() == n) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({avm_read, avm_write} !== 2'b00) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00", {avm_read, avm_write});
        end
        checks++;
        if (avm_address !== 5'd0 || avm_writedata !== 32'd0) begin
            errors++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", avm_address, avm_writedata);
        end
        checks++;
        if ({core_src_val, core_result_rdy} !== 2'b00) begin
            errors++; $display("FAIL reset_core_hs: got %b expected 00", {core_src_val, core_result_rdy});
        end
        checks++;
        if (core_a !== '0 || core_e !== '0 || core_n !== '0) begin
            errors++; $display("FAIL reset_operands: nonzero operand after reset");
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if ({avm_read, avm_write, avm_address} !== {1'b1, 1'b0, 5'd8}) begin
            errors++; $display("FAIL first_poll: got rd=%b wr=%b addr=%0d expected rd=1 wr=0 addr=8",
                               avm_read, avm_write, avm_address);
        end
    endtask

    task automatic test_load;
        bit ok;
        res_word = RES1;
        push_bytes(8'h01, 96);
        wait_src_val(1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL load_timeout: core_src_val=0 expected 1"); end
        checks++;
        if (core_n !== EXP_N) begin errors++; $display("FAIL load_n: got %h expected %h", core_n, EXP_N); end
        checks++;
        if (core_e !== EXP_E) begin errors++; $display("FAIL load_e: got %h expected %h", core_e, EXP_E); end
        checks++;
        if (core_a !== EXP_A) begin errors++; $display("FAIL load_a: got %h expected %h", core_a, EXP_A); end
        checks++;
        if (rx_q.size() !== 0) begin errors++; $display("FAIL load_consumed: %0d left expected 0", rx_q.size()); end
    endtask

    task automatic test_result;
        bit ok;
        logic [31:0] exp;
        wait_txq(31, 1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL result_timeout: %0d bytes written expected 31", tx_q.size()); end
        repeat (30) @(posedge i_clk);
        #1;
        checks++;
        if (tx_q.size() !== 31) begin errors++; $display("FAIL result_count: got %0d expected 31", tx_q.size()); end
        for (int i = 0; i < 31 && i < tx_q.size(); i++) begin
            exp = {24'h0, 8'h1e - 8'(i)};
            checks++;
            if (tx_q[i] !== exp) begin
                errors++; $display("FAIL result_byte%0d: got %h expected %h", i, tx_q[i], exp);
            end
        end
        checks++;
        if ({core_src_val, core_result_rdy, avm_write} !== 3'b000) begin
            errors++; $display("FAIL result_idle: got %b expected 000", {core_src_val, core_result_rdy, avm_write});
        end
    endtask

    task automatic test_second_cipher;
        bit ok;
        logic [31:0] exp;
        tx_q.delete();
        res_word = RES2;
        push_bytes(8'ha0, 32);
        wait_src_val(500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL second_timeout: core_src_val=0 expected 1"); end
        checks++;
        if (core_n !== EXP_N || core_e !== EXP_E) begin
            errors++; $display("FAIL second_ne_kept: n=%h e=%h expected %h %h", core_n, core_e, EXP_N, EXP_E);
        end
        checks++;
        if (core_a !== EXP_A2) begin errors++; $display("FAIL second_a: got %h expected %h", core_a, EXP_A2); end
        // Block TX_OK for 20 polls partway through transmission
        wait_txq(10, 500, ok);
        tx_ok_hold = 20;
        repeat (15) @(posedge i_clk);
        #1;
        checks++;
        if (tx_q.size() !== 10) begin errors++; $display("FAIL txok_hold: got %0d writes expected 10", tx_q.size()); end
        wait_txq(31, 1000, ok);
        repeat (20) @(posedge i_clk);
        #1;
        checks++;
        if (tx_q.size() !== 31) begin errors++; $display("FAIL second_count: got %0d expected 31", tx_q.size()); end
        for (int i = 0; i < 31 && i < tx_q.size(); i++) begin
            exp = {24'h0, 8'h80 + 8'(i)};
            checks++;
            if (tx_q[i] !== exp) begin
                errors++; $display("FAIL second_byte%0d: got %h expected %h", i, tx_q[i], exp);
            end
        end
        checks++;
        if (proto_err !== 0) begin errors++; $display("FAIL second_protocol: got %0d violations expected 0", proto_err); end
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [31:0] exp;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        rx_q.delete();
        tx_q.delete();
        i_rst = 1'b0;
        stall_cycles = 5;
        rx_ok_hold   = 10;
        res_word     = RES1;
        push_bytes(8'h01, 96);
        wait_src_val(4000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_load_timeout: core_src_val=0 expected 1"); end
        checks++;
        if (core_n !== EXP_N || core_e !== EXP_E || core_a !== EXP_A) begin
            errors++; $display("FAIL bp_operands: n=%h e=%h a=%h", core_n, core_e, core_a);
        end
        wait_txq(31, 2000, ok);
        repeat (20) @(posedge i_clk);
        #1;
        checks++;
        if (tx_q.size() !== 31) begin errors++; $display("FAIL bp_count: got %0d expected 31", tx_q.size()); end
        for (int i = 0; i < 31 && i < tx_q.size(); i++) begin
            exp = {24'h0, 8'h1e - 8'(i)};
            checks++;
            if (tx_q[i] !== exp) begin
                errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, tx_q[i], exp);
            end
        end
        checks++;
        if (stab_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes during stall expected 0", stab_err); end
        stall_cycles = 0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        // Reset after byte 50 of a fresh load
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        rx_q.delete();
        tx_q.delete();
        i_rst = 1'b0;
        push_bytes(8'h01, 96);
        wait_rxq(46, 500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst50_timeout: %0d bytes left expected 46", rx_q.size()); end
        i_rst = 1'b1;
        #1;
        checks++;
        if ({avm_read, avm_write, avm_address, avm_writedata, core_src_val, core_result_rdy} !== '0) begin
            errors++; $display("FAIL rst50_outputs: rd=%b wr=%b addr=%h nonzero after reset", avm_read, avm_write, avm_address);
        end
        checks++;
        if (core_a !== '0 || core_e !== '0 || core_n !== '0) begin
            errors++; $display("FAIL rst50_operands: nonzero operand after reset");
        end
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({avm_read, avm_write} !== 2'b00) begin
            errors++; $display("FAIL rst50_no_access: got %b expected 00", {avm_read, avm_write});
        end
        rx_q.delete();
        i_rst = 1'b0;
        // Reception restarts at core_n
        push_bytes(8'hc0, 32);
        wait_rxq(0, 500, ok);
        repeat (5) @(posedge i_clk);
        #1;
        checks++;
        if (core_n !== EXP_C0 || core_e !== '0 || core_a !== '0) begin
            errors++; $display("FAIL rst50_refill: n=%h e=%h a=%h expected n=%h e=0 a=0", core_n, core_e, core_a, EXP_C0);
        end
        // Reset while waiting for the core result
        push_bytes(8'h21, 64);
        ok = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge i_clk); #1;
            if (core_result_rdy === 1'b1) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_core_timeout: core_result_rdy=0 expected 1"); end
        i_rst = 1'b1;
        #1;
        checks++;
        if ({avm_read, avm_write, avm_address, avm_writedata, core_src_val, core_result_rdy} !== '0
            || core_a !== '0 || core_e !== '0 || core_n !== '0) begin
            errors++; $display("FAIL rstcore_outputs: rdy=%b src=%b rd=%b nonzero after reset",
                               core_result_rdy, core_src_val, avm_read);
        end
        repeat (2) @(posedge i_clk);
        #1;
        rx_q.delete();
        tx_q.delete();
        i_rst = 1'b0;
        push_bytes(8'h01, 32);
        wait_rxq(0, 500, ok);
        repeat (5) @(posedge i_clk);
        #1;
        checks++;
        if (core_n !== EXP_N || core_e !== '0) begin
            errors++; $display("FAIL rstcore_refill: n=%h e=%h expected n=%h e=0", core_n, core_e, EXP_N);
        end
        checks++;
        if (tx_q.size() !== 0 || proto_err !== 0) begin
            errors++; $display("FAIL rstcore_protocol: writes=%0d violations=%0d expected 0/0", tx_q.size(), proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_result();
        test_second_cipher();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_avmm_wrapper.md
RSA_AVMM_WRAPPER -- requirements
Module: rsa_avmm_wrapper

Interface
REQ-001 Parameter RX_BASE, default 0, byte address of the UART receive-data register.
REQ-002 Parameter TX_BASE, default 4, byte address of the UART transmit-data register.
REQ-003 Parameter STATUS_BASE, default 8, byte address of the UART status register.
REQ-004 Parameter RX_OK_BIT, default 7, status bit set when a received byte is available.
REQ-005 Parameter TX_OK_BIT, default 6, status bit set when the transmitter can accept a byte.
REQ-006 The clock SHALL be i_clk, input, 1 bit; all state updates on its rising edge.
REQ-007 The reset SHALL be i_rst, input, 1 bit, asynchronous, active-high.
REQ-008 avm_address  output  5   Avalon-MM master byte address.
REQ-009 avm_read  output  1   read request; avm_write  output  1   write request.
REQ-010 avm_readdata  input  32   read data; avm_writedata  output  32   write data.
REQ-011 avm_waitrequest  input  1   slave stall; the transfer completes in a cycle where it is low.
REQ-012 core_src_val  output  1 (operands valid); core_src_rdy  input  1 (core accepted operands).
REQ-013 core_a, core_e, core_n  output  256 each   ciphertext, exponent, modulus to the core.
REQ-014 core_result_val  input  1; core_result_rdy  output  1; core_result  input  256   a^e mod n.

Function
REQ-015 The FSM SHALL use states QUERY_RX, READ_RX, START_CORE, WAIT_CORE, QUERY_TX and WRITE_TX.
REQ-016 QUERY_RX SHALL drive avm_read=1 and avm_address=STATUS_BASE. On waitrequest low with readdata[RX_OK_BIT]=1 it SHALL go to READ_RX; otherwise it SHALL re-poll.
REQ-017 READ_RX SHALL drive avm_read=1 and avm_address=RX_BASE. On waitrequest low it SHALL shift readdata[7:0] into the LSB of the target register (reg <= {reg[247:0], byte}) and increment the byte counter.
REQ-018 Target register by 7-bit byte counter:
- 0-31: core_n.
- 32-63: core_e.
- 64-95: core_a.
- Each operand is received MSB byte first.
REQ-019 After byte 95 the FSM SHALL go to START_CORE; otherwise it SHALL return to QUERY_RX.
REQ-020 START_CORE SHALL hold core_src_val=1 with core_a/e/n stable until core_src_rdy=1 is sampled. It SHALL then drop core_src_val the next cycle and enter WAIT_CORE.
REQ-021 WAIT_CORE SHALL hold core_result_rdy=1. On core_result_val=1 it SHALL capture core_result, deassert core_result_rdy, and go to QUERY_TX.
REQ-022 QUERY_TX SHALL poll STATUS_BASE. On waitrequest low with readdata[TX_OK_BIT]=1 it SHALL go to WRITE_TX.
REQ-023 WRITE_TX SHALL drive avm_write=1, avm_address=TX_BASE and avm_writedata={24'b0, result[247:240]}. On waitrequest low it SHALL shift the result left 8 bits and increment the TX counter.
REQ-024 Exactly 31 bytes SHALL be written per result (result bits 247:0, MSB byte first). Bits 255:248 SHALL NOT be transmitted.
REQ-025 After the 31st byte the FSM SHALL set the byte counter to 64 and return to QUERY_RX. core_n and core_e SHALL be retained, and only the next 32-byte core_a SHALL be received.
REQ-026 While avm_waitrequest=1, avm_read, avm_write, avm_address and avm_writedata SHALL be held unchanged.
REQ-027 avm_read and avm_write SHALL never be asserted in the same cycle.
REQ-028 Outside their owning states, avm_read, avm_write, core_src_val and core_result_rdy SHALL be 0.
REQ-029 core_result_val asserted outside WAIT_CORE SHALL be ignored; the core holds it until core_result_rdy is seen.
REQ-030 A status read with the OK bit clear SHALL cost one transfer and SHALL NOT alter any counter or data register.

Reset
REQ-031 On i_rst=1 the block SHALL immediately force:
- outputs: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, core_src_val=0, core_result_rdy=0, core_a=core_e=core_n=0;
- internal state: FSM to QUERY_RX, both counters to 0, result register to 0.
REQ-032 Reset mid-transfer or mid-computation SHALL abandon the transfer with no further Avalon access. After release, reception SHALL restart at byte 0 (core_n).

Verification
REQ-033 Load: feed UART bytes 0x01..0x60 with RX_OK always set -> core_n=0x0102..20, core_e=0x2122..40, core_a=0x4142..60; core_src_val rises after byte 96.
REQ-034 Result: core model asserts core_src_rdy 3 cycles after core_src_val, then core_result_val with result bytes 0xFF,0x1E,0x1D..0x00 -> TX writes exactly 31 bytes 0x1E..0x00 in order; 0xFF is never written.
REQ-035 Back-pressure: avm_waitrequest high for 5 cycles on each read and write, and RX_OK clear for 10 polls -> address, read and write stay stable while stalled; data matches the no-stall run.
REQ-036 Second ciphertext: after the first result, feed 32 bytes 0xA0..0xBF -> core_n/core_e unchanged, core_a=0xA0A1..BF, second result transmitted.
REQ-037 Reset at byte 50 and again during WAIT_CORE -> all outputs 0 at once; the next load again fills core_n first.
REQ-038 TX_OK clear for 20 polls during transmission -> no write issued until TX_OK is set; byte order preserved.
